// File: rtl/photon_hls_deadlock_reporter_pkg.sv
// -----------------------------------------------------------------------------
// photon_hls_deadlock_reporter_pkg
// Shared types and constants for the deadlock reporter slice.
//   state_e   : reporter FSM states
//   REPORT_W  : width of the AXI-Stream report beat
//   *_LSB/_W  : bit positions and widths of the report fields
// -----------------------------------------------------------------------------
package photon_hls_deadlock_reporter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      CAPTURE,
      SEND,
      HOLD
   } state_e;

   localparam int REPORT_W    = 64;
   localparam int TS_LSB      = 32;
   localparam int TS_FIELD_W  = 32;
   localparam int CNT_LSB     = 16;
   localparam int CNT_FIELD_W = 16;
   localparam int INFO_LSB    = 0;

endpackage : photon_hls_deadlock_reporter_pkg

// File: rtl/photon_hls_deadlock_reporter_if.sv
// -----------------------------------------------------------------------------
// photon_hls_deadlock_reporter_if
// Bundles the monitor-side inputs and the AXI-Stream report channel.
//   block            : deadlock flag from the monitor (level)
//   axis_block_info  : per-channel block info, meaningful while block=1
//   report_tdata     : report beat {ts, count, pad, info}
//   report_tvalid    : AXIS valid
//   report_tready    : AXIS ready
// Modports:
//   master : the reporter (consumes monitor signals, drives the report)
//   slave  : the environment (drives monitor signals, sinks the report)
// -----------------------------------------------------------------------------
interface photon_hls_deadlock_reporter_if #(
   parameter int INFO_W = 9
) ();
   import photon_hls_deadlock_reporter_pkg::*;

   logic                block;
   logic [INFO_W-1:0]   axis_block_info;
   logic [REPORT_W-1:0] report_tdata;
   logic                report_tvalid;
   logic                report_tready;

   modport master (
      input  block,
      input  axis_block_info,
      input  report_tready,
      output report_tdata,
      output report_tvalid
   );

   modport slave (
      output block,
      output axis_block_info,
      output report_tready,
      input  report_tdata,
      input  report_tvalid
   );

endinterface : photon_hls_deadlock_reporter_if

// File: rtl/photon_hls_deadlock_persist_ctr.sv
// -----------------------------------------------------------------------------
// photon_hls_deadlock_persist_ctr
// Counts consecutive block cycles for the reporter FSM.
//   clk_i   : clock
//   rst_i   : synchronous reset, active-high
//   load_i  : load the count with 1 (first block cycle)
//   inc_i   : increment the count (another block cycle)
//   clr_i   : clear the count (stall ended or episode captured)
//   term_o  : the next increment reaches PERSIST
// Priority: clr_i > load_i > inc_i.
// -----------------------------------------------------------------------------
module photon_hls_deadlock_persist_ctr #(
   parameter int PERSIST = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic term_o
);

   localparam int PCNT_W = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);

   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_d;

   // NOTE: every signal assigned in always_comb gets a default on the first
   // line, so no path can leave it unassigned and infer a latch.
   always_comb begin
      pcnt_d = pcnt_q;
      if (clr_i) begin
         pcnt_d = '0;
      end else if (load_i) begin
         pcnt_d = PCNT_W'(1);
      end else if (inc_i) begin
         pcnt_d = pcnt_q + PCNT_W'(1);
      end
   end

   // Terminal is flagged one count early so the FSM can leave ARM on the
   // same edge that the count reaches PERSIST.
   assign term_o = (pcnt_q == PCNT_W'(PERSIST - 1));

   // NOTE: reset is sampled on the clock edge (synchronous), so it sits
   // inside the clocked branch rather than in the sensitivity list.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule : photon_hls_deadlock_persist_ctr

// File: rtl/photon_hls_deadlock_reporter.sv
// -----------------------------------------------------------------------------
// photon_hls_deadlock_reporter
// Filters transient stalls, latches one snapshot per deadlock episode and
// sends it as a single-beat AXI-Stream report.
//   clock_i        : clock
//   reset_i        : synchronous reset, active-high
//   clear_i        : one-cycle pulse, clears sticky_o and event_count_o
//   rpt_if         : monitor inputs and report channel (master modport)
//   sticky_o       : set by the first captured episode, held until clear/reset
//   event_count_o  : captured episodes, saturating at all-ones
// -----------------------------------------------------------------------------
module photon_hls_deadlock_reporter
   import photon_hls_deadlock_reporter_pkg::*;
#(
   parameter int INFO_W  = 9,
   parameter int PERSIST = 16,
   parameter int TS_W    = 32,
   parameter int CNT_W   = 16
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic                          clear_i,
   photon_hls_deadlock_reporter_if.master rpt_if,
   output logic                          sticky_o,
   output logic [CNT_W-1:0]              event_count_o
);

   state_e              state_q, state_d;
   logic [TS_W-1:0]     ts_q;
   logic [REPORT_W-1:0] tdata_q, tdata_d;
   logic                sticky_q, sticky_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic ctr_load, ctr_inc, ctr_clr, ctr_term;
   logic capture;

   photon_hls_deadlock_persist_ctr #(
      .PERSIST (PERSIST)
   ) u_persist_ctr (
      .clk_i  (clock_i),
      .rst_i  (reset_i),
      .load_i (ctr_load),
      .inc_i  (ctr_inc),
      .clr_i  (ctr_clr),
      .term_o (ctr_term)
   );

   // ---------------------------------------------------------------------------
   // FSM next-state and control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ctr_load = 1'b0;
      ctr_inc  = 1'b0;
      ctr_clr  = 1'b0;
      capture  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rpt_if.block) begin
               ctr_load = 1'b1;
               state_d  = (PERSIST == 1) ? CAPTURE : ARM;
            end
         end
         ARM: begin
            if (!rpt_if.block) begin
               ctr_clr = 1'b1;
               state_d = IDLE;
            end else begin
               ctr_inc = 1'b1;
               if (ctr_term) state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Snapshot is taken regardless of block; a drop here still reports.
            capture = 1'b1;
            ctr_clr = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (rpt_if.report_tready) state_d = HOLD;
         end
         HOLD: begin
            // One report per episode: re-arm only once block has gone low.
            if (!rpt_if.block) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Episode counter and sticky flag. A clear coinciding with CAPTURE is
   // applied before the increment, so that episode becomes count 1.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_base = clear_i ? '0 : count_q;
   assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

   always_comb begin
      count_d  = count_q;
      sticky_d = sticky_q;
      if (capture) begin
         count_d  = cnt_inc;
         sticky_d = 1'b1;
      end else if (clear_i) begin
         count_d  = '0;
         sticky_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Report fields: fit timestamp to 32 bits and count to 16 bits.
   // ---------------------------------------------------------------------------
   logic [TS_FIELD_W-1:0]  ts_field;
   logic [CNT_FIELD_W-1:0] cnt_field;

   if (TS_W >= TS_FIELD_W) begin : g_ts_trunc
      assign ts_field = ts_q[TS_FIELD_W-1:0];
   end else begin : g_ts_ext
      assign ts_field = {{(TS_FIELD_W-TS_W){1'b0}}, ts_q};
   end

   if (CNT_W >= CNT_FIELD_W) begin : g_cnt_trunc
      assign cnt_field = cnt_inc[CNT_FIELD_W-1:0];
   end else begin : g_cnt_ext
      assign cnt_field = {{(CNT_FIELD_W-CNT_W){1'b0}}, cnt_inc};
   end

   always_comb begin
      tdata_d = tdata_q;
      if (capture) begin
         tdata_d                           = '0;
         tdata_d[TS_LSB +: TS_FIELD_W]     = ts_field;
         tdata_d[CNT_LSB +: CNT_FIELD_W]   = cnt_field;
         tdata_d[INFO_LSB +: INFO_W]       = rpt_if.axis_block_info;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         ts_q     <= '0;
         tdata_q  <= '0;
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         ts_q     <= ts_q + TS_W'(1);
         tdata_q  <= tdata_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign rpt_if.report_tvalid = (state_q == SEND);
   assign rpt_if.report_tdata  = tdata_q;
   assign sticky_o             = sticky_q;
   assign event_count_o        = count_q;

endmodule : photon_hls_deadlock_reporter
